// File: rtl/fetch_pc_predictor.sv
// Fetch program counter with a direct-mapped branch target buffer.
// Each entry has a 2-bit saturating counter. Lookup is combinational on pc_o.
module fetch_pc_predictor #(
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX - 2;

  typedef logic [IDX-1:0]   idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic [31:0]            pc_q;
  logic [31:0]            pc_next;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  tag_t                   tag_q    [BTB_ENTRIES];
  logic [29:0]            target_q [BTB_ENTRIES];

  idx_t       l_idx, u_idx;
  tag_t       l_tag, u_tag;
  logic       l_hit, u_hit;
  logic [1:0] ctr_upd;

  // Low address bits are never stored or loaded; instructions are word aligned.
  logic unused_low_bits;
  assign unused_low_bits = ^{redirect_pc_i[1:0], update_pc_i[1:0], update_target_i[1:0]};

  // Lookup path
  assign l_idx         = pc_q[IDX+1:2];
  assign l_tag         = pc_q[31:IDX+2];
  assign l_hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign pred_taken_o  = l_hit && ctr_q[l_idx][1];
  assign pred_target_o = pred_taken_o ? {target_q[l_idx], 2'b00} : pc_plus4_o;

  // Update path
  assign u_idx = update_pc_i[IDX+1:2];
  assign u_tag = update_pc_i[31:IDX+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ctr_upd = ctr_q[u_idx];
    if (update_taken_i) begin
      if (ctr_q[u_idx] != 2'b11) ctr_upd = ctr_q[u_idx] + 2'd1;
    end else begin
      if (ctr_q[u_idx] != 2'b00) ctr_upd = ctr_q[u_idx] - 2'd1;
    end
  end

  always_comb begin
    pc_next = pred_target_o;
    if (redirect_i)   pc_next = {redirect_pc_i[31:2], 2'b00};
    else if (stall_i) pc_next = pc_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= 32'h0;
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      pc_q <= pc_next;
      if (update_valid_i) begin
        if (u_hit) begin
          ctr_q[u_idx] <= ctr_upd;
        end else if (update_taken_i) begin
          valid_q[u_idx] <= 1'b1;
          ctr_q[u_idx]   <= 2'b10;
        end
      end
    end
  end

  // NOTE: tag and target storage has no reset; a cleared valid bit already masks stale contents.
  always_ff @(posedge clk_i) begin
    if (update_valid_i && update_taken_i) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= update_target_i[31:2];
    end
  end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: the stimulus queues expected outputs per cycle.
// A negedge monitor pops each entry and compares it against the DUT.
module tb_fetch_pc_predictor;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        update_valid_i = 1'b0;
  logic [31:0] update_pc_i = '0;
  logic        update_taken_i = 1'b0;
  logic [31:0] update_target_i = '0;
  logic [31:0] pc_o, pc_plus4_o, pred_target_o;
  logic        pred_taken_o;

  fetch_pc_predictor #(.BTB_ENTRIES(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .update_target_i(update_target_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever the stimulus queued for the current cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL sb_sync: entry for cyc %0d seen at cyc %0d", mon_e.cyc, cyc);
      end else begin
        check("pc_o", pc_o, mon_e.pc);
        check("pc_plus4_o", pc_plus4_o, mon_e.pc + 32'd4);
        check("pred_taken_o", {31'd0, pred_taken_o}, {31'd0, mon_e.taken});
        check("pred_target_o", pred_target_o, mon_e.target);
      end
    end
  end

  // One cycle: drive inputs for the coming edge and queue the outputs expected now.
  task automatic go(input logic rst, input logic redir, input logic [31:0] rpc,
                    input logic stall, input logic uv, input logic [31:0] upc,
                    input logic ut, input logic [31:0] utgt,
                    input logic [31:0] epc, input logic etk, input logic [31:0] etgt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_ni          = rst;
    redirect_i      = redir;
    redirect_pc_i   = rpc;
    stall_i         = stall;
    update_valid_i  = uv;
    update_pc_i     = upc;
    update_taken_i  = ut;
    update_target_i = utgt;
    e.cyc    = cyc;
    e.pc     = epc;
    e.taken  = etk;
    e.target = etgt;
    sb.push_back(e);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

  initial begin
    #1 rst_ni = 1'b0;
    // Reset held: an update attempt must be ignored.
    go(0, 0, 0,     0, 1, 32'h8, 1, 32'h40,  32'h0, 0, 32'h4);
    go(0, 0, 0,     0, 1, 32'h8, 1, 32'h40,  32'h0, 0, 32'h4);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'h0, 0, 32'h4);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'h4, 0, 32'h8);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'h8, 0, 32'hC);
    // Allocate 0x8 -> 0x40, then refetch 0x8 and follow the prediction.
    go(1, 0, 0,     0, 1, 32'h8, 1, 32'h40,  32'hC, 0, 32'h10);
    go(1, 1, 32'h8, 0, 0, 0,     0, 0,       32'h10, 0, 32'h14);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'h8, 1, 32'h40);
    go(1, 1, 32'h8, 0, 0, 0,     0, 0,       32'h40, 0, 32'h44);
    // Counter walk while stalled at 0x8; same-cycle lookup sees pre-edge state.
    go(1, 0, 0,     1, 1, 32'h8, 0, 0,       32'h8, 1, 32'h40);
    go(1, 0, 0,     1, 1, 32'h8, 0, 0,       32'h8, 0, 32'hC);
    go(1, 0, 0,     1, 1, 32'h8, 0, 0,       32'h8, 0, 32'hC);
    go(1, 0, 0,     1, 1, 32'h8, 1, 32'h40,  32'h8, 0, 32'hC);
    go(1, 0, 0,     1, 1, 32'h8, 1, 32'h53,  32'h8, 0, 32'hC);
    go(1, 0, 0,     1, 1, 32'h8, 1, 32'h40,  32'h8, 1, 32'h50);
    go(1, 0, 0,     1, 1, 32'h8, 1, 32'h40,  32'h8, 1, 32'h40);
    go(1, 0, 0,     1, 1, 32'h8, 0, 0,       32'h8, 1, 32'h40);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'h8, 1, 32'h40);
    // Redirect with stall, then stall alone.
    go(1, 1, 32'h20,  0, 0, 0, 0, 0,         32'h40, 0, 32'h44);
    go(1, 1, 32'h103, 1, 0, 0, 0, 0,         32'h20, 0, 32'h24);
    go(1, 0, 0,     1, 0, 0,     0, 0,       32'h100, 0, 32'h104);
    go(1, 0, 0,     1, 0, 0,     0, 0,       32'h100, 0, 32'h104);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'h100, 0, 32'h104);
    // Alias at 0x48: not-taken miss leaves 0x8 alone, taken miss replaces it.
    go(1, 0, 0,     0, 1, 32'h48, 0, 0,      32'h104, 0, 32'h108);
    go(1, 1, 32'h8, 0, 0, 0,     0, 0,       32'h108, 0, 32'h10C);
    go(1, 0, 0,     1, 1, 32'h48, 1, 32'h80, 32'h8, 1, 32'h40);
    go(1, 1, 32'h48, 0, 0, 0,    0, 0,       32'h8, 0, 32'hC);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'h48, 1, 32'h80);
    // Top of the address space wraps pc+4 to zero.
    go(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0,   32'h80, 0, 32'h84);
    go(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'h40, 32'hFFFF_FFFC, 0, 32'h0);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'hFFFF_FFFC, 1, 32'h40);
    go(1, 0, 0,     1, 0, 0,     0, 0,       32'h40, 0, 32'h44);
    // Async reset between edges at 0x40 with redirect/stall/update pending.
    go(0, 1, 32'h200, 1, 1, 32'h8, 1, 32'h80, 32'h0, 0, 32'h4);
    go(0, 1, 32'h200, 1, 1, 32'h8, 1, 32'h80, 32'h0, 0, 32'h4);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'h0, 0, 32'h4);
    go(1, 1, 32'h8, 0, 0, 0,     0, 0,       32'h4, 0, 32'h8);
    go(1, 1, 32'h48, 0, 0, 0,    0, 0,       32'h8, 0, 32'hC);
    go(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0,   32'h48, 0, 32'h4C);
    go(1, 0, 0,     0, 0, 0,     0, 0,       32'hFFFF_FFFC, 0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
